// File: rtl/dmc_reader_pkg.sv
// ---------------------------------------------------------------------------
// dmc_reader_pkg
// Shared constants and types for the APU delta-modulation memory reader.
//   DMC_BASE_ADDR / DMC_WRAP_ADDR : default sample base and wrap addresses
//   dmc_state_t                   : DMA request FSM states
//   OP_*                          : bit positions in the one-hot register select
//   dmc_next_addr()               : sample address walk with wrap past $FFFF
// ---------------------------------------------------------------------------
package dmc_reader_pkg;

  localparam logic [15:0] DMC_BASE_ADDR = 16'hC000;
  localparam logic [15:0] DMC_WRAP_ADDR = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } dmc_state_t;

  localparam int OP_4010 = 0;
  localparam int OP_4011 = 1;
  localparam int OP_4012 = 2;
  localparam int OP_4013 = 3;

  // The sample pointer does not roll over to $0000; it continues at the wrap
  // address so playback stays inside the cartridge window.
  function automatic logic [15:0] dmc_next_addr(input logic [15:0] addr,
                                                input logic [15:0] wrap);
    return (addr == 16'hFFFF) ? wrap : addr + 16'd1;
  endfunction

endpackage

// File: rtl/dmc_reader_addr_counter.sv
// ---------------------------------------------------------------------------
// dmc_addr_counter
// Owns the current sample address and the 12-bit bytes-remaining count.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   load_i           : start playback (cur_addr <= start, count <= length)
//   clear_i          : stop playback (count <= 0); wins over load/step count
//   step_i           : one byte fetched: advance address, decrement count
//   loop_i           : restart from start_addr_i/start_len_i when count hits 0
//   start_addr_i     : programmed sample start address
//   start_len_i      : programmed sample length (bytes)
//   cur_addr_o       : address of the next byte to fetch
//   zero_o           : count == 0
//   last_o           : count == 1 (the next step ends the sample)
// ---------------------------------------------------------------------------
module dmc_addr_counter
  import dmc_reader_pkg::*;
#(
  parameter logic [15:0] WRAP_ADDR = DMC_WRAP_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        step_i,
  input  logic        loop_i,
  input  logic [15:0] start_addr_i,
  input  logic [11:0] start_len_i,
  output logic [15:0] cur_addr_o,
  output logic        zero_o,
  output logic        last_o
);

  logic [15:0] cur_addr_q, cur_addr_d;
  logic [11:0] rem_q, rem_d;

  always_comb begin
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;

    if (step_i) begin
      cur_addr_d = dmc_next_addr(cur_addr_q, WRAP_ADDR);
      // A step with a zero count is a byte fetched after a mid-request
      // disable: the address still advances but the count stays at zero.
      if (rem_q != 12'd0) begin
        rem_d = rem_q - 12'd1;
        if (rem_q == 12'd1 && loop_i) begin
          cur_addr_d = start_addr_i;
          rem_d      = start_len_i;
        end
      end
    end

    // Register writes override the fetch bookkeeping for the count.
    if (clear_i) begin
      rem_d = 12'd0;
    end else if (load_i) begin
      cur_addr_d = start_addr_i;
      rem_d      = start_len_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q <= 16'h0000;
      rem_q      <= 12'd0;
    end else begin
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign zero_o     = (rem_q == 12'd0);
  assign last_o     = (rem_q == 12'd1);

endmodule

// File: rtl/dmc_reader.sv
// ---------------------------------------------------------------------------
// dmc_reader
// Memory-reader half of the APU delta-modulation channel: holds the sample
// address/length registers, issues one-byte DMA reads, and keeps a one-byte
// sample buffer for the output unit.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   cpu_en              : CPU-cycle enable qualifying all register writes
//   op[3:0]             : one-hot select $4010/$4011/$4012/$4013
//   wdata[7:0]          : CPU write data
//   enable_we, enable   : $4015 write strobe and bit-4 value
//   dma_req, dma_addr   : read request and address to the DMA arbiter
//   dma_ack, dma_rdata  : request completion strobe and fetched byte
//   buf_take            : output unit consumes the buffer
//   buf_full, buf_data  : sample buffer status and contents
//   length_status       : bytes remaining != 0
//   irq                 : DMC interrupt flag
// Build option: define DMC_IRQ_EN to implement the interrupt; otherwise irq
// is tied low and the $4010 IRQ-enable bit is ignored.
// ---------------------------------------------------------------------------
module dmc_reader
  import dmc_reader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DMC_BASE_ADDR,
  parameter logic [15:0] WRAP_ADDR = DMC_WRAP_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic [3:0]  op,
  input  logic [7:0]  wdata,
  input  logic        enable_we,
  input  logic        enable,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  input  logic        dma_ack,
  input  logic [7:0]  dma_rdata,
  input  logic        buf_take,
  output logic        buf_full,
  output logic [7:0]  buf_data,
  output logic        length_status,
  output logic        irq
);

  // Write decode
  logic wr_ctrl, wr_addr, wr_len, wr_enable;
  assign wr_ctrl   = cpu_en & op[OP_4010];
  assign wr_addr   = cpu_en & op[OP_4012];
  assign wr_len    = cpu_en & op[OP_4013];
  assign wr_enable = cpu_en & enable_we;

  // $4011 belongs to the output unit.
  logic unused_op_4011;
  assign unused_op_4011 = op[OP_4011];

  // Channel registers
  logic        loop_q, loop_d;
  logic [15:0] sample_addr_q, sample_addr_d;
  logic [11:0] sample_len_q, sample_len_d;

  always_comb begin
    loop_d        = loop_q;
    sample_addr_d = sample_addr_q;
    sample_len_d  = sample_len_q;
    if (wr_ctrl) loop_d = wdata[6];
    if (wr_addr) sample_addr_d = BASE_ADDR + {2'b00, wdata, 6'b000000};
    if (wr_len)  sample_len_d  = {wdata, 4'b0000} + 12'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q        <= 1'b0;
      sample_addr_q <= 16'h0000;
      sample_len_q  <= 12'd0;
    end else begin
      loop_q        <= loop_d;
      sample_addr_q <= sample_addr_d;
      sample_len_q  <= sample_len_d;
    end
  end

  // Address / count
  dmc_state_t  state_q, state_d;
  logic        ack;
  logic [15:0] cnt_addr;
  logic        cnt_zero, cnt_last;

  // An ack is only meaningful against an outstanding request.
  assign ack = dma_ack & (state_q == REQ);

  dmc_addr_counter #(
    .WRAP_ADDR (WRAP_ADDR)
  ) u_addr_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (wr_enable & enable & cnt_zero),
    .clear_i      (wr_enable & ~enable),
    .step_i       (ack),
    .loop_i       (loop_q),
    .start_addr_i (sample_addr_q),
    .start_len_i  (sample_len_q),
    .cur_addr_o   (cnt_addr),
    .zero_o       (cnt_zero),
    .last_o       (cnt_last)
  );

  assign length_status = ~cnt_zero;

  // Request FSM and sample buffer
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_data_q, buf_data_d;

  always_comb begin
    state_d    = state_q;
    dma_addr_d = dma_addr_q;
    case (state_q)
      IDLE: begin
        if (!buf_full_q && !cnt_zero) begin
          state_d    = REQ;
          dma_addr_d = cnt_addr;
        end
      end
      REQ: begin
        // Held until the arbiter completes it, even across a disable.
        if (dma_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (ack) begin
      buf_full_d = 1'b1;
      buf_data_d = dma_rdata;
    end else if (buf_take) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dma_addr_q <= 16'h0000;
      buf_full_q <= 1'b0;
      buf_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      dma_addr_q <= dma_addr_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign dma_req  = (state_q == REQ);
  assign dma_addr = dma_addr_q;
  assign buf_full = buf_full_q;
  assign buf_data = buf_data_q;

  // Interrupt
`ifdef DMC_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = wr_ctrl ? wdata[7] : irq_en_q;
    irq_d    = irq_q;
    // Uses the post-write enable so a same-cycle $4010 clear suppresses it.
    if (ack && cnt_last && !loop_q && irq_en_d) irq_d = 1'b1;
    if (wr_ctrl && !wdata[7]) irq_d = 1'b0;
    if (wr_enable) irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_cnt_last;
  assign unused_cnt_last = cnt_last;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmc_reader.sv
module tb_dmc_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_en;
  logic [3:0]  op;
  logic [7:0]  wdata;
  logic        enable_we;
  logic        enable;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        buf_take;
  logic        buf_full;
  logic [7:0]  buf_data;
  logic        length_status;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef DMC_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // Reference model of the channel state
  logic [15:0] m_saddr, m_cur;
  logic [11:0] m_slen, m_rem;
  bit          m_loop, m_irq_en, m_irq;
  logic [7:0]  m_buf;

  always #5 clk = ~clk;

  dmc_reader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_en        (cpu_en),
    .op            (op),
    .wdata         (wdata),
    .enable_we     (enable_we),
    .enable        (enable),
    .dma_req       (dma_req),
    .dma_addr      (dma_addr),
    .dma_ack       (dma_ack),
    .dma_rdata     (dma_rdata),
    .buf_take      (buf_take),
    .buf_full      (buf_full),
    .buf_data      (buf_data),
    .length_status (length_status),
    .irq           (irq)
  );

  function automatic logic [15:0] next_addr(input logic [15:0] a);
    int n;
    n = int'(a) + 1;
    if (n > 65535) n = 32768;
    return 16'(n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cpu_en = 1'b0; op = 4'h0; wdata = 8'h00;
    enable_we = 1'b0; enable = 1'b0; dma_ack = 1'b0; dma_rdata = 8'h00;
    buf_take = 1'b0;
    m_saddr = 16'h0; m_cur = 16'h0; m_slen = 12'h0; m_rem = 12'h0;
    m_loop = 0; m_irq_en = 0; m_irq = 0; m_buf = 8'h0;
    #1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic wr(input int idx, input logic [7:0] d, input bit en_cpu);
    op = 4'(1 << idx); wdata = d; cpu_en = en_cpu;
    cyc();
    op = 4'h0; cpu_en = 1'b0;
    if (en_cpu) begin
      case (idx)
        0: begin
          m_irq_en = IRQ_ON && d[7];
          m_loop   = d[6];
          if (!d[7]) m_irq = 0;
        end
        2: m_saddr = 16'(32'hC000 + 32'(d) * 64);
        3: m_slen  = 12'(32'(d) * 16 + 1);
        default: ;
      endcase
    end
  endtask

  task automatic en_wr(input bit e);
    enable_we = 1'b1; enable = e; cpu_en = 1'b1;
    cyc();
    enable_we = 1'b0; cpu_en = 1'b0;
    m_irq = 0;
    if (!e) m_rem = 12'd0;
    else if (m_rem == 12'd0) begin
      m_cur = m_saddr;
      m_rem = m_slen;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dma_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic ack(input logic [7:0] d);
    $display("[TB] ack addr=%h data=%h", dma_addr, d);
    dma_rdata = d; dma_ack = 1'b1;
    cyc();
    dma_ack = 1'b0;
    m_buf = d;
    m_cur = next_addr(m_cur);
    if (m_rem != 12'd0) begin
      m_rem = m_rem - 12'd1;
      if (m_rem == 12'd0) begin
        if (m_loop) begin
          m_cur = m_saddr;
          m_rem = m_slen;
        end else if (m_irq_en) begin
          m_irq = 1;
        end
      end
    end
  endtask

  task automatic take();
    buf_take = 1'b1;
    cyc();
    buf_take = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    tests_run++;
    if ({dma_req, dma_addr, buf_full, buf_data, length_status, irq} !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %h expected 0",
               {dma_req, dma_addr, buf_full, buf_data, length_status, irq});
    end
    wr(2, 8'h33, 1); wr(3, 8'h02, 1); en_wr(1);
    wait_req(ok);
    ack(8'h5A);
    // Asynchronous reset asserted between clock edges
    #2; reset_n = 1'b0; #1;
    tests_run++;
    if ({dma_req, dma_addr, buf_full, buf_data, length_status, irq} !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected 0",
               {dma_req, dma_addr, buf_full, buf_data, length_status, irq});
    end
    do_reset();
    repeat (5) cyc();
    tests_run++;
    if (dma_req !== 1'b0 || length_status !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_req: got req=%b len=%b expected 0 0", dma_req, length_status);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    wr(2, 8'h01, 1); wr(3, 8'h00, 1); en_wr(1);
    wait_req(ok);
    tests_run++;
    if (!ok || dma_addr !== 16'hC040) begin
      tests_failed++;
      $display("FAIL single_req: got req=%b addr=%h expected 1 c040", ok, dma_addr);
    end
    ack(8'hA5);
    tests_run++;
    if (buf_full !== 1'b1 || buf_data !== 8'hA5 || length_status !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_buf: got full=%b data=%h len=%b expected 1 a5 0",
               buf_full, buf_data, length_status);
    end
    take();
    repeat (6) cyc();
    tests_run++;
    if (dma_req !== 1'b0 || buf_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: got req=%b full=%b expected 0 0", dma_req, buf_full);
    end
  endtask

  task automatic test_irq_count();
    bit ok;
    do_reset();
    wr(0, 8'h80, 1); wr(2, 8'h00, 1); wr(3, 8'h01, 1); en_wr(1);
    for (int i = 0; i < 17; i++) begin
      wait_req(ok);
      tests_run++;
      if (!ok || dma_addr !== m_cur || dma_addr !== 16'(16'hC000 + i)) begin
        tests_failed++;
        $display("FAIL irq_seq_addr[%0d]: got req=%b addr=%h expected 1 %h", i, ok, dma_addr, m_cur);
      end
      ack(8'($urandom));
      tests_run++;
      if (buf_data !== m_buf || irq !== m_irq || length_status !== (m_rem != 0)) begin
        tests_failed++;
        $display("FAIL irq_seq_state[%0d]: got data=%h irq=%b len=%b expected %h %b %b",
                 i, buf_data, irq, length_status, m_buf, m_irq, (m_rem != 0));
      end
      take();
    end
    tests_run++;
    if (irq !== IRQ_ON) begin
      tests_failed++;
      $display("FAIL irq_after_last: got %b expected %b", irq, IRQ_ON);
    end
    en_wr(0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear_by_enable: got %b expected 0", irq);
    end
  endtask

  task automatic test_loop();
    bit ok;
    do_reset();
    wr(0, 8'hC0, 1); wr(2, 8'h10, 1); wr(3, 8'h00, 1); en_wr(1);
    for (int i = 0; i < 6; i++) begin
      wait_req(ok);
      tests_run++;
      if (!ok || dma_addr !== 16'hC400) begin
        tests_failed++;
        $display("FAIL loop_addr[%0d]: got req=%b addr=%h expected 1 c400", i, ok, dma_addr);
      end
      ack(8'($urandom));
      tests_run++;
      if (irq !== 1'b0 || length_status !== 1'b1) begin
        tests_failed++;
        $display("FAIL loop_state[%0d]: got irq=%b len=%b expected 0 1", i, irq, length_status);
      end
      take();
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    wr(0, 8'h00, 1); wr(2, 8'hFF, 1); wr(3, 8'h04, 1); en_wr(1);
    for (int i = 0; i < 65; i++) begin
      wait_req(ok);
      tests_run++;
      if (!ok || dma_addr !== m_cur) begin
        tests_failed++;
        $display("FAIL wrap_addr[%0d]: got req=%b addr=%h expected 1 %h", i, ok, dma_addr, m_cur);
      end
      if (i == 63) begin
        tests_run++;
        if (dma_addr !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL wrap_top: got %h expected ffff", dma_addr);
        end
      end
      if (i == 64) begin
        tests_run++;
        if (dma_addr !== 16'h8000) begin
          tests_failed++;
          $display("FAIL wrap_to_8000: got %h expected 8000", dma_addr);
        end
      end
      ack(8'($urandom));
      take();
    end
    repeat (6) cyc();
    tests_run++;
    if (dma_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_done: got req=%b expected 0", dma_req);
    end
  endtask

  task automatic test_disable_mid();
    bit ok;
    do_reset();
    wr(2, 8'h02, 1); wr(3, 8'h01, 1); en_wr(1);
    wait_req(ok);
    en_wr(0);
    repeat (3) cyc();
    tests_run++;
    if (!ok || dma_req !== 1'b1 || dma_addr !== 16'hC080 || length_status !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_hold: got req=%b addr=%h len=%b expected 1 c080 0",
               dma_req, dma_addr, length_status);
    end
    ack(8'h77);
    tests_run++;
    if (buf_full !== 1'b1 || buf_data !== 8'h77 || dma_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_store: got full=%b data=%h req=%b expected 1 77 0",
               buf_full, buf_data, dma_req);
    end
    take();
    repeat (6) cyc();
    tests_run++;
    if (dma_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_no_more: got req=%b expected 0", dma_req);
    end
  endtask

  task automatic test_reenable();
    bit ok;
    do_reset();
    wr(2, 8'h00, 1); wr(3, 8'h01, 1); en_wr(1);
    for (int i = 0; i < 12; i++) begin
      wait_req(ok);
      ack(8'($urandom));
      if (i < 11) take();
    end
    en_wr(1);
    tests_run++;
    if (length_status !== 1'b1) begin
      tests_failed++;
      $display("FAIL reen_len: got %b expected 1", length_status);
    end
    take();
    wait_req(ok);
    tests_run++;
    if (!ok || dma_addr !== 16'hC00C || dma_addr !== m_cur) begin
      tests_failed++;
      $display("FAIL reen_addr: got req=%b addr=%h expected 1 c00c", ok, dma_addr);
    end
    ack(8'h3C);
    take();
  endtask

  task automatic test_random();
    bit ok;
    int kdis;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      wr(0, 8'($urandom), 1);
      wr(2, 8'($urandom), 1);
      wr(3, 8'($urandom_range(0, 2)), 1);
      // Writes without the CPU enable must be ignored
      wr(2 + $urandom_range(0, 1), 8'($urandom), 0);
      en_wr(1);
      kdis = $urandom_range(0, 70);
      for (int k = 0; k < 60; k++) begin
        wait_req(ok);
        tests_run++;
        if (!ok || dma_addr !== m_cur) begin
          tests_failed++;
          $display("FAIL rnd_addr[%0d.%0d]: got req=%b addr=%h expected 1 %h", r, k, ok, dma_addr, m_cur);
        end
        repeat ($urandom_range(0, 3)) cyc();
        if (k == kdis) en_wr(0);
        ack(8'($urandom));
        tests_run++;
        if (buf_data !== m_buf || irq !== m_irq || length_status !== (m_rem != 0)) begin
          tests_failed++;
          $display("FAIL rnd_state[%0d.%0d]: got data=%h irq=%b len=%b expected %h %b %b",
                   r, k, buf_data, irq, length_status, m_buf, m_irq, (m_rem != 0));
        end
        repeat ($urandom_range(0, 3)) cyc();
        tests_run++;
        if (dma_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_req_while_full[%0d.%0d]: got %b expected 0", r, k, dma_req);
        end
        take();
        if (m_rem == 12'd0) break;
      end
      if (m_rem == 12'd0) begin
        repeat (5) cyc();
        tests_run++;
        if (dma_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_end[%0d]: got req=%b expected 0", r, dma_req);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_irq_count();
    test_loop();
    test_wrap();
    test_disable_mid();
    test_reenable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmc_reader.md
Name: dmc_reader

Overview:
- Memory-reader half of the APU delta-modulation channel. The sibling channels only consume CPU register writes; this block turns register state into CPU-bus read requests.
- Holds the sample address/length registers and walks the sample address.
- Issues one-byte DMA read requests to the CPU stall/DMA arbiter.
- Presents a one-byte sample buffer to the DMC output unit; drives the channel length status and IRQ.

Parameters:
- BASE_ADDR, 16'hC000, sample start base; start = BASE_ADDR + wdata*64.
- WRAP_ADDR, 16'h8000, address loaded after 16'hFFFF.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_en  in  1  CPU-cycle clock enable; qualifies all register writes
- op  in  4  one-hot register select: [0] $4010, [1] $4011 (ignored here), [2] $4012, [3] $4013
- wdata  in  8  CPU write data
- enable_we  in  1  $4015 write strobe, qualified by cpu_en
- enable  in  1  $4015 bit 4 value
- dma_req  out  1  read request to the DMA arbiter
- dma_addr  out  16  read address, stable while dma_req=1
- dma_ack  in  1  one-cycle strobe: dma_rdata valid, request complete
- dma_rdata  in  8  fetched byte
- buf_take  in  1  output unit consumes buffer (one-cycle strobe)
- buf_full  out  1  sample buffer holds a byte
- buf_data  out  8  sample buffer contents
- length_status  out  1  bytes_remaining != 0 (for $4015 read)
- irq  out  1  DMC interrupt flag

Behaviour:
- Reset (asynchronous, reset_n=0) clears all of the following:
  - outputs: dma_req=0, dma_addr=0, buf_full=0, buf_data=0, length_status=0, irq=0;
  - internal registers: irq_en, loop, sample_addr, sample_len, cur_addr, bytes_remaining (12 bit).
  - FSM returns to IDLE.
- Register writes take effect only when cpu_en=1:
  - op[0]: irq_en<=wdata[7], loop<=wdata[6]. If wdata[7]=0, irq<=0.
  - op[2]: sample_addr<=BASE_ADDR + {wdata,6'b0}.
  - op[3]: sample_len<={wdata,4'b0}+1. Range 1..4081.
- Enable write (cpu_en & enable_we):
  - irq<=0 in all cases.
  - enable=0: bytes_remaining<=0.
  - enable=1 with bytes_remaining=0: cur_addr<=sample_addr, bytes_remaining<=sample_len.
  - enable=1 with bytes_remaining!=0: no change.
- FSM states: IDLE, REQ.
  - IDLE->REQ when buf_full=0 and bytes_remaining!=0. Next cycle dma_req=1, dma_addr=cur_addr.
  - REQ: dma_req and dma_addr are held until dma_ack, even if a disable arrives meanwhile.
  - On dma_ack:
    - buf_data<=dma_rdata, buf_full<=1, state->IDLE.
    - cur_addr<=(cur_addr==16'hFFFF) ? WRAP_ADDR : cur_addr+1.
    - If bytes_remaining!=0: decrement.
    - If the decrement reaches 0 and loop=1: reload cur_addr=sample_addr, bytes_remaining=sample_len.
    - If the decrement reaches 0 and loop=0: irq<=1 if irq_en.
    - If bytes_remaining was already 0 (disabled mid-request): byte is stored, no decrement, no irq.
- Buffer:
  - buf_take with buf_full=1 clears buf_full.
  - buf_take with buf_full=0 is ignored.
  - dma_ack can only occur while buf_full=0, so ack and take never conflict.
- Simultaneous events in one cycle:
  - Enable write with dma_ack: enable write wins for bytes_remaining; the ack still fills the buffer.
  - op[0] clearing irq_en with dma_ack: the irq is not set.
- length_status is combinational from bytes_remaining.
- Latency: buffer empties -> dma_req asserted 1 cycle later (registered).

Optional Feature:
- Macro: DMC_IRQ_EN.
- Defined: irq behaves as above.
- Undefined: irq tied 0, irq_en register removed, op[0] bit 7 ignored; all other behaviour unchanged.

Decomposition:
- Shared apu package holds:
  - DMC_BASE_ADDR and DMC_WRAP_ADDR constants (parameter defaults);
  - dmc_state_t enum {IDLE, REQ};
  - op bit index constants for $4010-$4013.
- Natural sub-module: dmc_addr_counter. Owns cur_addr and bytes_remaining, with load/step/clear inputs and zero/last outputs.

Test Plan:
- Reset, then write $4012=8'h01 and $4013=8'h00, then enable=1 -> dma_req with dma_addr=16'hC040; ack with 8'hA5 -> buf_full=1, buf_data=8'hA5, length_status=0, no further dma_req.
- $4013=8'h01 (17 bytes), loop=0, irq_en=1; ack and take 17 times -> addresses C000..C010 issued, irq=1 after the 17th ack; an enable write then clears irq.
- loop=1, length 1 -> after each take, a new request to the same address; irq never set; length_status stays 1.
- $4012=8'hFF (start FFC0), length 65 -> 64th request at FFFF, 65th at 8000.
- Disable while dma_req=1 -> dma_req held until ack, byte stored, length_status=0, no new request after take.
- Enable=1 while bytes_remaining=5 -> cur_addr and count unchanged; next request continues at the previous address.
